// File: rtl/hp_fifo_n.sv
// hp_fifo_n: dual-clock FIFO from the host (falling h_phi2) to the parasite (rising p_clk) with latch, burst and stream modes.
// Define HP_FIFO_ERR_FLAGS_EN to build the sticky h_overflow / p_underflow flags; otherwise both are tied low.
module hp_fifo_n #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int BURST = 2
) (
    input  logic             h_phi2,
    input  logic             h_rst_b,
    input  logic             p_clk,
    input  logic             p_clk_en,
    input  logic             h_selectData,
    input  logic             h_we_b,
    input  logic [WIDTH-1:0] h_data,
    input  logic             p_selectData,
    input  logic             p_rdnw,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] p_data,
    output logic             p_data_available,
    output logic             p_burst_available,
    output logic             h_full,
    output logic             h_overflow,
    output logic             p_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] BURST_C = PW'(BURST);
    localparam logic [PW-1:0] ONE_C   = PW'(1);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // mode 11 behaves exactly like stream
    logic mode_latch;
    logic mode_burst;
    assign mode_latch = (mode == 2'b00);
    assign mode_burst = (mode == 2'b01);

    logic [WIDTH-1:0] mem [DEPTH];

    // host domain state
    logic [PW-1:0] wptr_bin;
    logic [PW-1:0] wptr_gray;
    logic [PW-1:0] rgray_sync_p1;
    logic [PW-1:0] rgray_sync_p2;
    logic          h_burst_bit;

    // parasite domain state
    logic [PW-1:0] rptr_bin;
    logic [PW-1:0] rptr_gray;
    logic [PW-1:0] wgray_sync_p1;
    logic [PW-1:0] wgray_sync_p2;
    logic          p_burst_bit;

    logic          h_wr;
    logic          h_wr_ok;
    logic [PW-1:0] hc;
    logic [PW-1:0] hc_nxt;
    logic [PW-1:0] wptr_nxt;
    logic          h_burst_nxt;

    logic          p_pop;
    logic          p_pop_ok;
    logic [PW-1:0] pc;
    logic [PW-1:0] pc_nxt;
    logic [PW-1:0] rptr_nxt;
    logic          p_burst_nxt;

    // ---------------- host side: count, flow control, write acceptance
    assign h_wr = h_selectData & ~h_we_b;
    assign hc   = wptr_bin - gray2bin(rgray_sync_p2);

    always_comb begin
        if (mode_burst) begin
            h_full = h_burst_bit;
        end else if (mode_latch) begin
            h_full = (hc >= ONE_C);
        end else begin
            h_full = (hc == DEPTH_C);
        end
    end

    assign h_wr_ok  = h_wr & (hc < DEPTH_C) & ~h_full;
    assign wptr_nxt = h_wr_ok ? (wptr_bin + ONE_C) : wptr_bin;

    // Count as it will stand after this edge, so the burst bit tracks the write that causes it.
    assign hc_nxt = wptr_nxt - gray2bin(rgray_sync_p1);

    always_comb begin
        h_burst_nxt = h_burst_bit;
        if (!mode_burst) begin
            h_burst_nxt = 1'b0;
        end else if (hc_nxt == '0) begin
            h_burst_nxt = 1'b0;
        end else if (hc_nxt >= BURST_C) begin
            h_burst_nxt = 1'b1;
        end
    end

    always_ff @(negedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            wptr_bin      <= '0;
            wptr_gray     <= '0;
            rgray_sync_p1 <= '0;
            rgray_sync_p2 <= '0;
            h_burst_bit   <= 1'b0;
        end else begin
            wptr_bin      <= wptr_nxt;
            wptr_gray     <= bin2gray(wptr_nxt);
            rgray_sync_p1 <= rptr_gray;
            rgray_sync_p2 <= rgray_sync_p1;
            h_burst_bit   <= h_burst_nxt;
        end
    end

    always_ff @(negedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (h_wr_ok) begin
            mem[wptr_bin[AW-1:0]] <= h_data;
        end
    end

    // ---------------- parasite side: count, flow control, pop acceptance
    assign p_pop = p_selectData & p_rdnw & p_clk_en;
    assign pc    = gray2bin(wgray_sync_p2) - rptr_bin;

    always_comb begin
        if (mode_burst) begin
            p_data_available = p_burst_bit;
        end else begin
            p_data_available = (pc >= ONE_C);
        end
    end

    assign p_burst_available = mode_burst & (pc >= BURST_C);
    assign p_data            = mem[rptr_bin[AW-1:0]];

    assign p_pop_ok = p_pop & (pc != '0) & p_data_available;
    assign rptr_nxt = p_pop_ok ? (rptr_bin + ONE_C) : rptr_bin;
    assign pc_nxt   = gray2bin(wgray_sync_p1) - rptr_nxt;

    always_comb begin
        p_burst_nxt = p_burst_bit;
        if (!mode_burst) begin
            p_burst_nxt = 1'b0;
        end else if (pc_nxt == '0) begin
            p_burst_nxt = 1'b0;
        end else if (pc_nxt >= BURST_C) begin
            p_burst_nxt = 1'b1;
        end
    end

    always_ff @(posedge p_clk or negedge h_rst_b) begin
        if (!h_rst_b) begin
            rptr_bin      <= '0;
            rptr_gray     <= '0;
            wgray_sync_p1 <= '0;
            wgray_sync_p2 <= '0;
            p_burst_bit   <= 1'b0;
        end else begin
            rptr_bin      <= rptr_nxt;
            rptr_gray     <= bin2gray(rptr_nxt);
            wgray_sync_p1 <= wptr_gray;
            wgray_sync_p2 <= wgray_sync_p1;
            p_burst_bit   <= p_burst_nxt;
        end
    end

    // ---------------- optional sticky error flags
`ifdef HP_FIFO_ERR_FLAGS_EN
    always_ff @(negedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            h_overflow <= 1'b0;
        end else if (h_wr & ~h_wr_ok) begin
            h_overflow <= 1'b1;
        end
    end

    always_ff @(posedge p_clk or negedge h_rst_b) begin
        if (!h_rst_b) begin
            p_underflow <= 1'b0;
        end else if (p_pop & ~p_pop_ok) begin
            p_underflow <= 1'b1;
        end
    end
`else
    assign h_overflow  = 1'b0;
    assign p_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_hp_fifo_n.sv
// Directed bench for hp_fifo_n: stream, burst, latch, underflow, mid-transfer reset and a randomised stream run.
module tb_hp_fifo_n;

`ifdef HP_FIFO_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       h_phi2 = 1'b1;
    logic       p_clk = 1'b0;
    logic       h_rst_b = 1'b1;
    logic       p_clk_en = 1'b1;
    logic       h_selectData = 1'b0;
    logic       h_we_b = 1'b1;
    logic [7:0] h_data = 8'h00;
    logic       p_selectData = 1'b0;
    logic       p_rdnw = 1'b0;
    logic [1:0] mode = 2'b10;
    logic [7:0] p_data;
    logic       p_data_available;
    logic       p_burst_available;
    logic       h_full;
    logic       h_overflow;
    logic       p_underflow;

    int checks = 0;
    int failures = 0;

    // p_clk runs 3.7x faster than h_phi2
    always #37 h_phi2 = ~h_phi2;
    always #10 p_clk = ~p_clk;

    hp_fifo_n #(.DEPTH(4), .WIDTH(8), .BURST(2)) dut (
        .h_phi2            (h_phi2),
        .h_rst_b           (h_rst_b),
        .p_clk             (p_clk),
        .p_clk_en          (p_clk_en),
        .h_selectData      (h_selectData),
        .h_we_b            (h_we_b),
        .h_data            (h_data),
        .p_selectData      (p_selectData),
        .p_rdnw            (p_rdnw),
        .mode              (mode),
        .p_data            (p_data),
        .p_data_available  (p_data_available),
        .p_burst_available (p_burst_available),
        .h_full            (h_full),
        .h_overflow        (h_overflow),
        .p_underflow       (p_underflow)
    );

    task automatic host_write(input logic [7:0] d);
        @(posedge h_phi2);
        h_selectData = 1'b1;
        h_we_b       = 1'b0;
        h_data       = d;
        @(negedge h_phi2);
        #1;
        h_selectData = 1'b0;
        h_we_b       = 1'b1;
    endtask

    task automatic pop(output logic [7:0] d);
        @(negedge p_clk);
        d            = p_data;
        p_selectData = 1'b1;
        p_rdnw       = 1'b1;
        @(posedge p_clk);
        #1;
        p_selectData = 1'b0;
        p_rdnw       = 1'b0;
    endtask

    task automatic wait_p(input int n);
        repeat (n) @(posedge p_clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] m);
        @(posedge h_phi2);
        #3;
        h_rst_b = 1'b0;
        mode    = m;
        @(posedge h_phi2);
        #5;
        h_rst_b = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        h_rst_b = 1'b0;
        #3;
        checks++;
        if ({p_data, p_data_available, p_burst_available, h_full, h_overflow, p_underflow} !== 13'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {p_data, p_data_available, p_burst_available, h_full, h_overflow, p_underflow});
        end
        @(posedge h_phi2);
        #5;
        h_rst_b = 1'b1;
        wait_p(2);
        checks++;
        if ({p_data_available, h_full} !== 2'b00) begin
            failures++;
            $display("FAIL after_reset_flags got=%b exp=00", {p_data_available, h_full});
        end
    endtask

    task automatic test_stream();
        logic [7:0] got;
        do_reset(2'b10);
        for (int i = 0; i < 4; i++) begin
            host_write(8'hA1 + 8'(i));
            checks++;
            if (h_full !== (i == 3)) begin
                failures++;
                $display("FAIL stream_h_full_%0d got=%b exp=%b", i, h_full, (i == 3));
            end
        end
        host_write(8'h55);
        checks++;
        if ({h_full, h_overflow} !== {1'b1, ERR_EN}) begin
            failures++;
            $display("FAIL stream_overflow got=%b exp=%b", {h_full, h_overflow}, {1'b1, ERR_EN});
        end
        wait_p(3);
        checks++;
        if ({p_data_available, p_burst_available} !== 2'b10) begin
            failures++;
            $display("FAIL stream_avail got=%b exp=10", {p_data_available, p_burst_available});
        end
        for (int i = 0; i < 4; i++) begin
            pop(got);
            checks++;
            if (got !== 8'hA1 + 8'(i)) begin
                failures++;
                $display("FAIL stream_pop_%0d got=%h exp=%h", i, got, 8'hA1 + 8'(i));
            end
        end
        checks++;
        if (p_data_available !== 1'b0) begin
            failures++;
            $display("FAIL stream_empty got=%b exp=0", p_data_available);
        end
        for (int k = 0; k < 3 && h_full; k++) begin
            @(negedge h_phi2);
            #1;
        end
        checks++;
        if (h_full !== 1'b0) begin
            failures++;
            $display("FAIL stream_full_clear got=%b exp=0", h_full);
        end
    endtask

    task automatic test_burst();
        logic [7:0] got;
        do_reset(2'b01);
        host_write(8'h11);
        checks++;
        if (h_full !== 1'b0) begin
            failures++;
            $display("FAIL burst_full_1 got=%b exp=0", h_full);
        end
        wait_p(4);
        checks++;
        if ({p_data_available, p_burst_available} !== 2'b00) begin
            failures++;
            $display("FAIL burst_one_entry got=%b exp=00", {p_data_available, p_burst_available});
        end
        host_write(8'h22);
        checks++;
        if (h_full !== 1'b1) begin
            failures++;
            $display("FAIL burst_full_2 got=%b exp=1", h_full);
        end
        for (int k = 0; k < 3 && !p_data_available; k++) begin
            @(posedge p_clk);
            #1;
        end
        checks++;
        if ({p_data_available, p_burst_available} !== 2'b11) begin
            failures++;
            $display("FAIL burst_avail got=%b exp=11", {p_data_available, p_burst_available});
        end
        pop(got);
        checks++;
        if (got !== 8'h11) begin
            failures++;
            $display("FAIL burst_pop1 got=%h exp=11", got);
        end
        checks++;
        if ({p_data_available, p_burst_available, p_data} !== {2'b10, 8'h22}) begin
            failures++;
            $display("FAIL burst_after_pop1 got=%h exp=%h", {p_data_available, p_burst_available, p_data}, {2'b10, 8'h22});
        end
        pop(got);
        checks++;
        if (got !== 8'h22) begin
            failures++;
            $display("FAIL burst_pop2 got=%h exp=22", got);
        end
        checks++;
        if ({p_data_available, h_full} !== 2'b01) begin
            failures++;
            $display("FAIL burst_after_pop2 got=%b exp=01", {p_data_available, h_full});
        end
        for (int k = 0; k < 3 && h_full; k++) begin
            @(negedge h_phi2);
            #1;
        end
        checks++;
        if (h_full !== 1'b0) begin
            failures++;
            $display("FAIL burst_full_clear got=%b exp=0", h_full);
        end
    endtask

    task automatic test_latch();
        logic [7:0] got;
        do_reset(2'b00);
        host_write(8'h5A);
        checks++;
        if (h_full !== 1'b1) begin
            failures++;
            $display("FAIL latch_full got=%b exp=1", h_full);
        end
        host_write(8'hA5);
        checks++;
        if (h_overflow !== ERR_EN) begin
            failures++;
            $display("FAIL latch_overflow got=%b exp=%b", h_overflow, ERR_EN);
        end
        for (int k = 0; k < 3 && !p_data_available; k++) begin
            @(posedge p_clk);
            #1;
        end
        pop(got);
        checks++;
        if (got !== 8'h5A) begin
            failures++;
            $display("FAIL latch_pop got=%h exp=5a", got);
        end
        checks++;
        if (p_data_available !== 1'b0) begin
            failures++;
            $display("FAIL latch_empty got=%b exp=0", p_data_available);
        end
        for (int k = 0; k < 3 && h_full; k++) begin
            @(negedge h_phi2);
            #1;
        end
        checks++;
        if (h_full !== 1'b0) begin
            failures++;
            $display("FAIL latch_full_clear got=%b exp=0", h_full);
        end
        host_write(8'hC3);
        wait_p(3);
        pop(got);
        checks++;
        if (got !== 8'hC3) begin
            failures++;
            $display("FAIL latch_second got=%h exp=c3", got);
        end
    endtask

    task automatic test_underflow();
        logic [7:0] got;
        do_reset(2'b10);
        pop(got);
        checks++;
        if ({p_underflow, p_data_available, p_data} !== {ERR_EN, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL underflow_flag got=%h exp=%h", {p_underflow, p_data_available, p_data}, {ERR_EN, 1'b0, 8'h00});
        end
        host_write(8'h33);
        wait_p(3);
        p_clk_en = 1'b0;
        pop(got);
        p_clk_en = 1'b1;
        checks++;
        if ({p_data_available, p_data} !== {1'b1, 8'h33}) begin
            failures++;
            $display("FAIL clk_en_gate got=%h exp=%h", {p_data_available, p_data}, {1'b1, 8'h33});
        end
        pop(got);
        checks++;
        if ({got, p_data_available} !== {8'h33, 1'b0}) begin
            failures++;
            $display("FAIL underflow_rptr got=%h exp=%h", {got, p_data_available}, {8'h33, 1'b0});
        end
    endtask

    task automatic test_reset_midway();
        logic [7:0] got;
        do_reset(2'b10);
        host_write(8'h01);
        host_write(8'h02);
        host_write(8'h03);
        wait_p(3);
        checks++;
        if (p_data_available !== 1'b1) begin
            failures++;
            $display("FAIL midway_queued got=%b exp=1", p_data_available);
        end
        @(posedge h_phi2);
        #3;
        h_rst_b = 1'b0;
        #1;
        checks++;
        if ({p_data, p_data_available, p_burst_available, h_full, h_overflow, p_underflow} !== 13'h0) begin
            failures++;
            $display("FAIL midway_reset got=%h exp=0",
                     {p_data, p_data_available, p_burst_available, h_full, h_overflow, p_underflow});
        end
        @(posedge h_phi2);
        #5;
        h_rst_b = 1'b1;
        host_write(8'h77);
        wait_p(3);
        pop(got);
        checks++;
        if ({got, p_data_available} !== {8'h77, 1'b0}) begin
            failures++;
            $display("FAIL midway_first_write got=%h exp=%h", {got, p_data_available}, {8'h77, 1'b0});
        end
    endtask

    task automatic test_random_stream();
        int rd_cnt;
        rd_cnt = 0;
        do_reset(2'b10);
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int guard;
                    guard = 0;
                    repeat ($urandom_range(0, 1)) @(posedge h_phi2);
                    @(posedge h_phi2);
                    while (h_full && guard < 200) begin
                        @(posedge h_phi2);
                        guard++;
                    end
                    h_selectData = 1'b1;
                    h_we_b       = 1'b0;
                    h_data       = 8'(i * 37 + 5);
                    @(negedge h_phi2);
                    #1;
                    h_selectData = 1'b0;
                    h_we_b       = 1'b1;
                end
            end
            begin
                for (int cyc = 0; cyc < 3000 && rd_cnt < 40; cyc++) begin
                    @(negedge p_clk);
                    if (p_data_available && $urandom_range(0, 3) != 0) begin
                        checks++;
                        if (p_data !== 8'(rd_cnt * 37 + 5)) begin
                            failures++;
                            $display("FAIL rand_data_%0d got=%h exp=%h", rd_cnt, p_data, 8'(rd_cnt * 37 + 5));
                        end
                        p_selectData = 1'b1;
                        p_rdnw       = 1'b1;
                        rd_cnt++;
                        @(posedge p_clk);
                        #1;
                        p_selectData = 1'b0;
                        p_rdnw       = 1'b0;
                    end
                end
            end
        join
        wait_p(4);
        checks++;
        if (rd_cnt !== 40) begin
            failures++;
            $display("FAIL rand_count got=%0d exp=40", rd_cnt);
        end
        checks++;
        if ({p_data_available, h_overflow, p_underflow} !== 3'b000) begin
            failures++;
            $display("FAIL rand_final_flags got=%b exp=000", {p_data_available, h_overflow, p_underflow});
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_burst();
        test_latch();
        test_underflow();
        test_reset_midway();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
